accumulator_shift_capture: RTL and testbench

Serial-in, parallel-out receiver for the accumulator shift register's serial stream.
- Start is asserted on the same edge the transmitter parallel-loads (L=1).
- The block then samples Sin on the next WIDTH rising edges, LSB first, and presents the assembled word on Dout with a Valid/Ack handshake.
- It sits at the far end of the accumulator serial link and feeds the result back into the parallel datapath.

---
 rtl/accumulator_shift_capture_if.sv | 23 ++
 rtl/accumulator_shift_capture.sv | 67 ++++++
 tb/tb_accumulator_shift_capture.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accumulator_shift_capture_if.sv
// Handshake/data bundle between the serial capture block and its consumer.
// The master side drives Start/Sin/Ack; the slave side (the receiver) returns the word and status.
interface accumulator_shift_capture_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sin;
  logic             ack;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             busy;
  logic             overrun;

  modport master (
    output start, sin, ack,
    input  dout, valid, busy, overrun
  );

  modport slave (
    input  start, sin, ack,
    output dout, valid, busy, overrun
  );
endinterface

// File: rtl/accumulator_shift_capture.sv
// Serial-in, parallel-out receiver for the accumulator serial link.
// Captures WIDTH bits LSB first after Start and hands the word over with Valid/Ack.
module accumulator_shift_capture #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input logic                        clk,
  input logic                        rst_n,
  accumulator_shift_capture_if.slave bus
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  // Bit 0 of a full-width shifter would only ever be shifted out, so just the upper WIDTH-1 bits are held.
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] word;
  logic             last_bit;

  assign word     = {bus.sin, shreg};
  assign last_bit = (state == SHIFT) && (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      shreg       <= '0;
      bus.dout    <= '0;
      bus.valid   <= 1'b0;
      bus.busy    <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      // A word finishing on the Ack edge wins: the new word becomes the pending one.
      if (last_bit) begin
        bus.dout  <= word;
        bus.valid <= 1'b1;
        if (bus.valid && !bus.ack) begin
          bus.overrun <= 1'b1;
        end
      end else if (bus.ack) begin
        bus.valid <= 1'b0;
      end

      // Start always (re)opens a capture; on the completing edge the word above still lands.
      if (bus.start) begin
        state    <= SHIFT;
        count    <= '0;
        shreg    <= '0;
        bus.busy <= 1'b1;
      end else if (state == SHIFT) begin
        shreg <= word[WIDTH-1:1];
        if (last_bit) begin
          state    <= IDLE;
          count    <= '0;
          bus.busy <= 1'b0;
        end else begin
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_accumulator_shift_capture.sv
// Self-checking bench for accumulator_shift_capture: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_accumulator_shift_capture;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  accumulator_shift_capture_if #(.WIDTH(WIDTH)) bus ();

  accumulator_shift_capture #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a capture is a list of received bits; a word is done when the list is full.
  logic             m_cap;
  logic             m_bits[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_valid;
  logic             m_busy;
  logic             m_over;

  function automatic void model_reset();
    m_cap = 1'b0;
    m_bits.delete();
    m_dout = '0;
    m_valid = 1'b0;
    m_busy = 1'b0;
    m_over = 1'b0;
  endfunction

  function automatic void model_step(input logic st, input logic s, input logic a);
    logic             done;
    logic [WIDTH-1:0] w;
    done = 1'b0;
    w = '0;
    if (m_cap) begin
      m_bits.push_back(s);
      if (m_bits.size() == WIDTH) begin
        done = 1'b1;
        for (int i = 0; i < WIDTH; i++) w[i] = m_bits[i];
      end
    end
    if (done) begin
      if (m_valid && !a) m_over = 1'b1;
      m_dout = w;
      m_valid = 1'b1;
    end else if (a) begin
      m_valid = 1'b0;
    end
    if (st) begin
      m_cap = 1'b1;
      m_bits.delete();
    end else if (done) begin
      m_cap = 1'b0;
      m_bits.delete();
    end
    m_busy = m_cap;
  endfunction

  task automatic applyStimulus(input logic st, input logic s, input logic a);
    @(negedge clk);
    bus.start = st;
    bus.sin   = s;
    bus.ack   = a;
    @(posedge clk);
    model_step(st, s, a);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.start = 1'b0;
    bus.sin   = 1'b0;
    bus.ack   = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic start_last, input int ack_at);
    for (int i = 0; i < WIDTH; i++) begin
      applyStimulus(start_last && (i == WIDTH - 1), w[i], ack_at == i);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({bus.dout, bus.valid, bus.busy, bus.overrun} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset: got dout=%h valid=%b busy=%b ovr=%b, want 00 0 0 0",
               bus.dout, bus.valid, bus.busy, bus.overrun);
    end
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'hA4;
    do_reset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      total++;
      if (bus.busy !== 1'b1 || bus.valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL basic_busy edge %0d: got busy=%b valid=%b, want 1 0", i, bus.busy, bus.valid);
      end
      applyStimulus(1'b0, w[i], 1'b0);
    end
    total++;
    if ({bus.dout, bus.valid, bus.busy, bus.overrun} !== {8'hA4, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL basic_done: got dout=%h valid=%b busy=%b ovr=%b, want a4 1 0 0",
               bus.dout, bus.valid, bus.busy, bus.overrun);
    end
  endtask

  task automatic test_handshake();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      total++;
      if (bus.dout !== 8'hA4 || bus.valid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL hold %0d: got dout=%h valid=%b, want a4 1", i, bus.dout, bus.valid);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    total++;
    if (bus.dout !== 8'hA4 || bus.valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ack_clear: got dout=%h valid=%b, want a4 0", bus.dout, bus.valid);
    end
  endtask

  task automatic test_overrun();
    applyStimulus(1'b1, 1'b0, 1'b0);
    send_word(8'hA4, 1'b0, -1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    send_word(8'h00, 1'b0, -1);
    total++;
    if ({bus.dout, bus.valid, bus.overrun} !== {8'h00, 1'b1, 1'b1}) begin
      bad++;
      $display("[TB] FAIL overrun_set: got dout=%h valid=%b ovr=%b, want 00 1 1",
               bus.dout, bus.valid, bus.overrun);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    total++;
    if ({bus.valid, bus.overrun} !== {1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL overrun_sticky: got valid=%b ovr=%b, want 0 1", bus.valid, bus.overrun);
    end
  endtask

  task automatic test_ack_on_completion();
    do_reset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0, -1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0, WIDTH - 1);
    total++;
    if ({bus.dout, bus.valid, bus.overrun} !== {8'hFF, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL ack_on_done: got dout=%h valid=%b ovr=%b, want ff 1 0",
               bus.dout, bus.valid, bus.overrun);
    end
  endtask

  task automatic test_restart();
    logic [7:0] w;
    w = 8'h5A;
    do_reset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      total++;
      if (bus.valid !== 1'b0 || bus.dout !== 8'h00 || bus.busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL restart_partial %0d: got dout=%h valid=%b busy=%b, want 00 0 1",
                 i, bus.dout, bus.valid, bus.busy);
      end
      applyStimulus(1'b0, w[i], 1'b0);
    end
    total++;
    if ({bus.dout, bus.valid, bus.busy} !== {8'h5A, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL restart_done: got dout=%h valid=%b busy=%b, want 5a 1 0",
               bus.dout, bus.valid, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    send_word(8'h96, 1'b1, -1);
    total++;
    if ({bus.dout, bus.valid, bus.busy} !== {8'h96, 1'b1, 1'b1}) begin
      bad++;
      $display("[TB] FAIL b2b_first: got dout=%h valid=%b busy=%b, want 96 1 1",
               bus.dout, bus.valid, bus.busy);
    end
    send_word(8'h3C, 1'b0, 0);
    total++;
    if ({bus.dout, bus.valid, bus.busy, bus.overrun} !== {8'h3C, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL b2b_second: got dout=%h valid=%b busy=%b ovr=%b, want 3c 1 0 0",
               bus.dout, bus.valid, bus.busy, bus.overrun);
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({bus.dout, bus.valid, bus.busy, bus.overrun} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL async_reset: got dout=%h valid=%b busy=%b ovr=%b, want 00 0 0 0",
               bus.dout, bus.valid, bus.busy, bus.overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0, -1);
    total++;
    if ({bus.dout, bus.valid, bus.busy, bus.overrun} !== {8'hC3, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL after_reset: got dout=%h valid=%b busy=%b ovr=%b, want c3 1 0 0",
               bus.dout, bus.valid, bus.busy, bus.overrun);
    end
  endtask

  task automatic test_random();
    logic st, s, a;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      st = ($urandom_range(0, 11) == 0);
      s  = 1'($urandom);
      a  = ($urandom_range(0, 4) == 0);
      applyStimulus(st, s, a);
      total++;
      if (bus.dout !== m_dout || bus.valid !== m_valid || bus.busy !== m_busy || bus.overrun !== m_over) begin
        bad++;
        $display("[TB] FAIL random edge %0d: got dout=%h valid=%b busy=%b ovr=%b, want %h %b %b %b",
                 n, bus.dout, bus.valid, bus.busy, bus.overrun, m_dout, m_valid, m_busy, m_over);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sin   = 1'b0;
    bus.ack   = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_handshake();
    test_overrun();
    test_ack_on_completion();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
